alu_seq: RTL



---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_seq_if.sv | 29 ++
 rtl/alu_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, flag bit positions and sequencer state type for the 8-bit ALU execute stage.
// Used by the sequencer and its interface; holds no logic beyond the legality check.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_ADDC = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_SUBC = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_INR  = 4'h8;
  localparam logic [3:0] OP_DCR  = 4'h9;
  localparam logic [3:0] OP_RLC  = 4'hA;
  localparam logic [3:0] OP_LOAD = 4'hF;

  localparam int FLAG_PAR = 3;
  localparam int FLAG_CY  = 2;
  localparam int FLAG_SGN = 1;
  localparam int FLAG_ZER = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  // Wide requests are only meaningful as two-pass ADD/SUB; LOAD is narrow-only.
  function automatic logic op_legal(input logic [3:0] op, input logic wide);
    logic ok;
    ok = 1'b0;
    if (wide) begin
      ok = (op == OP_ADD) || (op == OP_SUB);
    end else begin
      case (op)
        OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_AND, OP_OR, OP_XOR,
        OP_CMP, OP_INR, OP_DCR, OP_RLC, OP_LOAD: ok = 1'b1;
        default:                                 ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request handshake plus ALU operand/result bus between the sequencer and its parent.
// slave = sequencer side; master = requester and ALU side.
interface alu_seq_if;
  import alu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic        req_wide;
  logic [15:0] req_b;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_cin;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_result;
  logic [3:0]  alu_flags;

  modport slave (
    input  req_valid, req_op, req_wide, req_b, alu_result, alu_flags,
    output req_ready, alu_a, alu_b, alu_cin, alu_sel
  );

  modport master (
    output req_valid, req_op, req_wide, req_b, alu_result, alu_flags,
    input  req_ready, alu_a, alu_b, alu_cin, alu_sel
  );

endinterface

// File: rtl/alu_seq.sv
// Execute-stage sequencer around the 8-bit ALU: accumulator/flags writeback, 16-bit ADD/SUB in two passes.
// done at accept+2 (narrow), +3 (wide), +1 (LOAD/err); req_ready low only while an ALU pass is in flight.
module alu_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output logic [15:0] acc_q,
  output logic [3:0]  flags_q,
  output logic        done,
  output logic        err,
  output logic        busy
);

  state_t      state;
  logic [3:0]  op_reg;
  logic        wide_reg;
  logic [15:0] b_reg;
  logic [7:0]  lo_byte;
  logic        lo_carry;
  logic        lo_zero;

  logic [7:0]  alu_a_mux;
  logic [7:0]  alu_b_mux;
  logic        alu_cin_mux;
  logic [3:0]  alu_sel_mux;

  always_comb begin
    alu_a_mux   = 8'h00;
    alu_b_mux   = 8'h00;
    alu_cin_mux = 1'b0;
    alu_sel_mux = 4'h0;
    case (state)
      LO: begin
        alu_a_mux   = acc_q[7:0];
        alu_b_mux   = b_reg[7:0];
        alu_sel_mux = op_reg;
        // A wide op starts its carry chain fresh; narrow ops chain off the flag register.
        alu_cin_mux = wide_reg ? 1'b0 : flags_q[FLAG_CY];
      end
      HI: begin
        alu_a_mux   = acc_q[15:8];
        alu_b_mux   = b_reg[15:8];
        alu_sel_mux = (op_reg == OP_SUB) ? OP_SUBC : OP_ADDC;
        alu_cin_mux = lo_carry;
      end
      default: ;
    endcase
  end

  assign bus.alu_a     = alu_a_mux;
  assign bus.alu_b     = alu_b_mux;
  assign bus.alu_cin   = alu_cin_mux;
  assign bus.alu_sel   = alu_sel_mux;
  assign bus.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_reg   <= 4'h0;
      wide_reg <= 1'b0;
      b_reg    <= 16'h0000;
      lo_byte  <= 8'h00;
      lo_carry <= 1'b0;
      lo_zero  <= 1'b0;
      acc_q    <= 16'h0000;
      flags_q  <= 4'h0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_reg   <= bus.req_op;
            wide_reg <= bus.req_wide;
            b_reg    <= bus.req_b;
            if (!op_legal(bus.req_op, bus.req_wide)) begin
              err <= 1'b1;
            end else if (bus.req_op == OP_LOAD) begin
              acc_q <= bus.req_b;
              done  <= 1'b1;
            end else begin
              state <= LO;
            end
          end
        end
        LO: begin
          if (wide_reg) begin
            lo_byte  <= bus.alu_result;
            lo_carry <= bus.alu_flags[FLAG_CY];
            lo_zero  <= bus.alu_flags[FLAG_ZER];
            state    <= HI;
          end else begin
            if (op_reg != OP_CMP) begin
              acc_q[7:0] <= bus.alu_result;
            end
            flags_q <= bus.alu_flags;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
        HI: begin
          acc_q   <= {bus.alu_result, lo_byte};
          // 16-bit zero needs both bytes zero; the other flags come from the high pass alone.
          flags_q <= {bus.alu_flags[FLAG_PAR], bus.alu_flags[FLAG_CY],
                      bus.alu_flags[FLAG_SGN], bus.alu_flags[FLAG_ZER] & lo_zero};
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
